ps2_kbd_ctrl: RTL and testbench
===============================

// Module: ps2_kbd_ctrl
// PURPOSE
//  Drains the PS/2 keyboard receiver FIFO and turns raw scan-code bytes (set 2) into whole key events.
//  Handles E0/F0/E1 prefixes, tracks modifier state and keeps sticky error status.
//  Presents one event at a time to the CPU MMIO side with a valid/ack handshake.
//  Sits between ps2_kbd (ready/read/data/overflow) and the bus slave; the top ties ps2_kbd clrn = ~rst.
// PARAMETERS
//  TIMEOUT_CYCLES  2000000  max clk cycles between bytes of one multi-byte sequence (20 ms @100 MHz)
// PORTS
//  clk           in   1  system clock; everything is on posedge
//  rst           in   1  synchronous, active-high reset
//  kbd_ready     in   1  ps2_kbd FIFO non-empty
//  kbd_data      in   8  ps2_kbd head-of-FIFO byte (combinational from the FIFO)
//  kbd_overflow  in   1  ps2_kbd sticky overflow
//  kbd_read      out  1  pop strobe to ps2_kbd; the byte is consumed at the edge where it is 1
//  evt_valid     out  1  event register holds an unread event
//  evt_code      out  8  final scan code of the event
//  evt_ext       out  1  event was E0-prefixed (also 1 for Pause)
//  evt_rel       out  1  event is a break (key release)
//  evt_mods      out  4  {caps_lock, alt, ctrl, shift} snapshot after this event is applied
//  evt_ack       in   1  consumer pops the event; ignored when evt_valid=0
//  err_status    out  3  sticky {timeout, kbd_err, overflow}
//  err_clr       in   1  clears err_status (the same-cycle set wins)
// BEHAVIOUR
//  Reset: state=IDLE, all evt_* =0, err_status=0, modifiers=0, timer=0, pause_cnt=0; kbd_read=0 while rst=1.
//  kbd_read (comb.) = ~rst & kbd_ready & ~stall, where stall = evt_valid & ~evt_ack.
//    Back-to-back pops on consecutive cycles are legal.
//  FSM, advanced by each consumed byte b:
//    IDLE:    E0->EXT; F0->REL; E1->PAUSE (pause_cnt=7); AA->drop; 00/FF->drop, set kbd_err; else emit make(b).
//    EXT:     F0->EXT_REL; E0/E1->drop, stay in EXT; 12 or 59 (fake shift)->IDLE with no event;
//             else emit ext make(b), go IDLE.
//    REL:     emit break(b), go IDLE.
//    EXT_REL: 12/59->IDLE with no event; else emit ext break(b), go IDLE.
//    PAUSE:   pause_cnt-=1 per byte, contents ignored; the byte that takes it 1->0 emits code=E1, ext=1, rel=0.
//  Emit: the event register loads at the consuming edge, so evt_* are valid the next cycle (latency 1).
//    Because of stall there is never an overwrite; ack and a new load in the same cycle keep evt_valid=1.
//  Modifiers are updated at the emit edge, before the snapshot is taken:
//    shift = lshift(12) | rshift(59).
//    ctrl  = lctrl(14) | rctrl(E0 14).
//    alt   = lalt(11) | ralt(E0 11).
//    Make sets the held bit; break clears it.
//    caps_lock toggles on a make of 58 only when 58 was not already held (typematic repeats do not toggle).
//  Timer: reloads to 0 on every consumed byte and counts while state != IDLE.
//    On reaching TIMEOUT_CYCLES-1: state=IDLE, pause_cnt=0, set timeout, no event.
//  overflow bit = sticky OR of kbd_overflow. err_clr zeroes bits not being set that cycle.
//  Reset mid-sequence drops the partial sequence and any pending event; the FIFO is reset by the top.
// TESTING
//  1 Bytes 1C; no ack -> evt_valid=1 1 cycle after pop, code=1C ext=0 rel=0 mods=0; next byte stays in FIFO, kbd_read=0.
//  2 12, 1C, F0 1C, F0 12, acking each -> events (12,mk,mods=1), (1C,mk,mods=1), (1C,rel,mods=1), (12,rel,mods=0).
//  3 E0 F0 75 -> one event code=75 ext=1 rel=1; E0 12 E0 7C -> one event code=7C ext=1 only.
//  4 E1 14 77 E1 F0 14 F0 77 -> exactly one event code=E1 ext=1 after the 8th byte.
//    58,58,F0 58,58 -> caps_lock 1, 1, 1, 0.
//  5 TIMEOUT_CYCLES=16: E0, then 16 idle cycles -> err_status=100, state IDLE; next 1C gives ext=0.
//    err_clr -> err_status=000.
//  6 rst asserted after F0 -> all outputs 0; then 1C gives a make (rel=0).
//    kbd_overflow pulse -> err_status[0]=1 until err_clr.

Source files
------------

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 set-2 scan-code decoder: drains the receiver FIFO, tracks modifiers
// and errors, and presents whole key events over a valid/ack handshake.
// Ports:
//   clk, rst                      clock, sync active-high reset
//   kbd_ready, kbd_data           FIFO non-empty flag and head byte
//   kbd_overflow                  sticky FIFO overflow from the receiver
//   kbd_read                      pop strobe back to the FIFO
//   evt_valid, evt_code, evt_ext  event register contents
//   evt_rel, evt_mods             break flag, {caps,alt,ctrl,shift}
//   evt_ack                       consumer pops the event
//   err_status, err_clr           sticky {timeout,kbd_err,overflow}, clear
module ps2_kbd_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       kbd_ready,
  input  logic [7:0] kbd_data,
  input  logic       kbd_overflow,
  output logic       kbd_read,
  output logic       evt_valid,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_rel,
  output logic [3:0] evt_mods,
  input  logic       evt_ack,
  output logic [2:0] err_status,
  input  logic       err_clr
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_REL,
    S_EXT_REL,
    S_PAUSE
  } state_t;

  state_t        state, n_state;
  logic [TW-1:0] timer;
  logic [2:0]    pcnt, n_pcnt;

  logic lsh, rsh, lctl, rctl, lalt, ralt;
  logic caps_held, caps;
  logic n_lsh, n_rsh, n_lctl, n_rctl;
  logic n_lalt, n_ralt, n_caps_held, n_caps;

  logic       stall;
  logic       emit, e_ext, e_rel, e_pause;
  logic [7:0] e_code;
  logic       kerr, tmo;
  logic       fake;

  assign stall    = evt_valid & ~evt_ack;
  assign kbd_read = ~rst & kbd_ready & ~stall;
  assign fake     = (kbd_data == 8'h12) | (kbd_data == 8'h59);

  // Byte-driven sequence decoder
  always_comb begin
    n_state = state;
    n_pcnt  = pcnt;
    emit    = 1'b0;
    e_ext   = 1'b0;
    e_rel   = 1'b0;
    e_pause = 1'b0;
    e_code  = kbd_data;
    kerr    = 1'b0;
    if (kbd_read) begin
      unique case (state)
        S_IDLE: begin
          unique case (1'b1)
            kbd_data == 8'hE0: n_state = S_EXT;
            kbd_data == 8'hF0: n_state = S_REL;
            kbd_data == 8'hE1: begin
              n_state = S_PAUSE;
              n_pcnt  = 3'd7;
            end
            kbd_data == 8'hAA: ;
            kbd_data == 8'h00,
            kbd_data == 8'hFF: kerr = 1'b1;
            default: emit = 1'b1;
          endcase
        end
        S_EXT: begin
          unique case (1'b1)
            kbd_data == 8'hF0: n_state = S_EXT_REL;
            kbd_data == 8'hE0,
            kbd_data == 8'hE1: ;
            fake: n_state = S_IDLE;
            default: begin
              emit    = 1'b1;
              e_ext   = 1'b1;
              n_state = S_IDLE;
            end
          endcase
        end
        S_REL: begin
          emit    = 1'b1;
          e_rel   = 1'b1;
          n_state = S_IDLE;
        end
        S_EXT_REL: begin
          n_state = S_IDLE;
          if (!fake) begin
            emit  = 1'b1;
            e_ext = 1'b1;
            e_rel = 1'b1;
          end
        end
        S_PAUSE: begin
          n_pcnt = pcnt - 3'd1;
          if (pcnt == 3'd1) begin
            emit    = 1'b1;
            e_ext   = 1'b1;
            e_pause = 1'b1;
            e_code  = 8'hE1;
            n_state = S_IDLE;
          end
        end
        default: n_state = S_IDLE;
      endcase
    end
  end

  // Modifier state after applying the emitted event
  always_comb begin
    n_lsh       = lsh;
    n_rsh       = rsh;
    n_lctl      = lctl;
    n_rctl      = rctl;
    n_lalt      = lalt;
    n_ralt      = ralt;
    n_caps_held = caps_held;
    n_caps      = caps;
    if (emit && !e_pause) begin
      if (!e_ext) begin
        if (e_code == 8'h12) n_lsh  = ~e_rel;
        if (e_code == 8'h59) n_rsh  = ~e_rel;
        if (e_code == 8'h14) n_lctl = ~e_rel;
        if (e_code == 8'h11) n_lalt = ~e_rel;
        if (e_code == 8'h58) begin
          // Typematic repeats arrive while held and must not toggle
          if (!e_rel && !caps_held) n_caps = ~caps;
          n_caps_held = ~e_rel;
        end
      end else begin
        if (e_code == 8'h14) n_rctl = ~e_rel;
        if (e_code == 8'h11) n_ralt = ~e_rel;
      end
    end
  end

  assign tmo = ~kbd_read & (state != S_IDLE) & (timer == T_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      timer      <= '0;
      pcnt       <= '0;
      lsh        <= 1'b0;
      rsh        <= 1'b0;
      lctl       <= 1'b0;
      rctl       <= 1'b0;
      lalt       <= 1'b0;
      ralt       <= 1'b0;
      caps_held  <= 1'b0;
      caps       <= 1'b0;
      evt_valid  <= 1'b0;
      evt_code   <= '0;
      evt_ext    <= 1'b0;
      evt_rel    <= 1'b0;
      evt_mods   <= '0;
      err_status <= '0;
    end else begin
      if (kbd_read) begin
        state <= n_state;
        pcnt  <= n_pcnt;
        timer <= '0;
      end else if (tmo) begin
        state <= S_IDLE;
        pcnt  <= '0;
        timer <= '0;
      end else if (state != S_IDLE) begin
        timer <= timer + 1'b1;
      end

      lsh       <= n_lsh;
      rsh       <= n_rsh;
      lctl      <= n_lctl;
      rctl      <= n_rctl;
      lalt      <= n_lalt;
      ralt      <= n_ralt;
      caps_held <= n_caps_held;
      caps      <= n_caps;

      if (emit) begin
        evt_valid <= 1'b1;
        evt_code  <= e_code;
        evt_ext   <= e_ext;
        evt_rel   <= e_rel;
        evt_mods  <= {n_caps, n_lalt | n_ralt,
                      n_lctl | n_rctl, n_lsh | n_rsh};
      end else if (evt_ack) begin
        evt_valid <= 1'b0;
      end

      err_status <= {tmo, kerr, kbd_overflow}
                  | (err_status & ~{3{err_clr}});
    end
  end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Scoreboard bench for ps2_kbd_ctrl: a queue-based FIFO feeds bytes, a
// sequence-level key model predicts events, a monitor pops and compares.
module tb_ps2_kbd_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       kbd_ready = 1'b0;
  logic [7:0] kbd_data = '0;
  logic       kbd_overflow = 1'b0;
  logic       kbd_read;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_rel;
  logic [3:0] evt_mods;
  logic       evt_ack = 1'b0;
  logic [2:0] err_status;
  logic       err_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  ps2_kbd_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .kbd_ready(kbd_ready), .kbd_data(kbd_data),
    .kbd_overflow(kbd_overflow), .kbd_read(kbd_read),
    .evt_valid(evt_valid), .evt_code(evt_code),
    .evt_ext(evt_ext), .evt_rel(evt_rel), .evt_mods(evt_mods),
    .evt_ack(evt_ack), .err_status(err_status), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // ---------- byte FIFO ----------
  logic [7:0] fq[$];

  function automatic void refresh();
    kbd_ready = (fq.size() != 0);
    kbd_data  = (fq.size() != 0) ? fq[0] : 8'h00;
  endfunction

  always @(posedge clk) begin
    if (kbd_read) begin
      #1;
      void'(fq.pop_front());
      refresh();
    end
  end

  task automatic push_bytes(input logic [7:0] s[$]);
    foreach (s[i]) fq.push_back(s[i]);
    refresh();
  endtask

  // ---------- reference model ----------
  // expected event = {code, ext, rel, mods}
  logic [14:0] exp_q[$];
  bit held[512];
  bit caps_m;

  function automatic void model_reset();
    foreach (held[i]) held[i] = 1'b0;
    caps_m = 1'b0;
  endfunction

  function automatic logic [3:0] mods_now();
    logic sh, ct, al;
    sh = held[9'h012] | held[9'h059];
    ct = held[9'h014] | held[9'h114];
    al = held[9'h011] | held[9'h111];
    return {caps_m, al, ct, sh};
  endfunction

  task automatic model_seq(input logic [7:0] s[$]);
    logic       ext, rel;
    logic [7:0] c;
    int         k;
    if (s[0] == 8'hE1) begin
      exp_q.push_back({8'hE1, 1'b1, 1'b0, mods_now()});
      return;
    end
    k   = 0;
    ext = 1'b0;
    rel = 1'b0;
    if (s[k] == 8'hE0) begin ext = 1'b1; k++; end
    if (s[k] == 8'hF0) begin rel = 1'b1; k++; end
    c = s[k];
    if (ext && (c == 8'h12 || c == 8'h59)) return;
    if (!ext && !rel && (c == 8'hAA || c == 8'h00 || c == 8'hFF))
      return;
    if (!ext && c == 8'h58 && !rel && !held[{1'b0, c}])
      caps_m = ~caps_m;
    held[{ext, c}] = ~rel;
    exp_q.push_back({c, ext, rel, mods_now()});
  endtask

  task automatic send(input logic [7:0] s[$]);
    model_seq(s);
    push_bytes(s);
  endtask

  // ---------- monitor ----------
  bit auto_ack = 1'b1;
  bit seen = 1'b0;
  int dly = 0;

  always @(negedge clk) begin
    if (rst) begin
      seen    = 1'b0;
      evt_ack = 1'b0;
    end else begin
      if (evt_valid && !seen) begin
        logic [14:0] act, e;
        act = {evt_code, evt_ext, evt_rel, evt_mods};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event got %h required none", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            errors++;
            $display("FAIL event got code=%h ext=%b rel=%b mods=%b required code=%h ext=%b rel=%b mods=%b",
                     act[14:7], act[6], act[5], act[4:0] & 5'h0f,
                     e[14:7], e[6], e[5], e[3:0]);
          end
        end
        seen = 1'b1;
        dly  = $urandom_range(0, 3);
      end
      evt_ack = 1'b0;
      if (seen && auto_ack) begin
        if (dly == 0) begin
          evt_ack = 1'b1;
          seen    = 1'b0;
        end else begin
          dly--;
        end
      end
    end
  end

  // ---------- helpers ----------
  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h required %0h", name, act, req);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((fq.size() != 0 || exp_q.size() != 0 || evt_valid) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL drain_%s got fifo=%0d pending=%0d required 0 0",
               name, fq.size(), exp_q.size());
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  function automatic logic [7:0] pick_code();
    logic [7:0] l[8];
    l = '{8'h12, 8'h59, 8'h14, 8'h11, 8'h58, 8'h1C, 8'h75, 8'h7C};
    if ($urandom_range(0, 2) == 0) return 8'($urandom_range(1, 8'h7F));
    return l[$urandom_range(0, 7)];
  endfunction

  // ---------- stimulus ----------
  initial begin
    logic [7:0] c;
    int n;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(evt_valid), 0);
    check("rst_err", 32'(err_status), 0);
    check("rst_read", 32'(kbd_read), 0);
    rst = 1'b0;
    @(negedge clk);

    // single make held without ack: stall keeps next byte in FIFO
    auto_ack = 1'b0;
    send('{8'h1C});
    send('{8'h1C});
    n = 0;
    while (!evt_valid && n < 50) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    check("stall_read", 32'(kbd_read), 0);
    check("stall_fifo", 32'(fq.size()), 1);
    auto_ack = 1'b1;
    drain("t1");

    // shifted key make/break
    send('{8'h12});
    send('{8'h1C});
    send('{8'hF0, 8'h1C});
    send('{8'hF0, 8'h12});
    drain("t2");

    // extended break, fake shift
    send('{8'hE0, 8'hF0, 8'h75});
    send('{8'hE0, 8'h12});
    send('{8'hE0, 8'h7C});
    drain("t3");

    // pause and caps lock
    send('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77});
    send('{8'h58});
    send('{8'h58});
    send('{8'hF0, 8'h58});
    send('{8'h58});
    drain("t4");

    // timeout after lone E0
    push_bytes('{8'hE0});
    drain("t5a");
    repeat (17) @(negedge clk);
    check("timeout_err", 32'(err_status), 32'b100);
    send('{8'h1C});
    drain("t5b");
    pulse_clr();
    check("timeout_clr", 32'(err_status), 0);

    // bad byte
    push_bytes('{8'h00});
    drain("kerr");
    @(negedge clk);
    check("kbd_err", 32'(err_status), 32'b010);
    pulse_clr();

    // reset mid-sequence
    push_bytes('{8'hF0});
    drain("t6a");
    rst = 1'b1;
    fq.delete();
    model_reset();
    push_bytes('{8'h1C});
    @(negedge clk);
    check("midrst_valid", 32'(evt_valid), 0);
    check("midrst_mods", 32'(evt_mods), 0);
    check("midrst_read", 32'(kbd_read), 0);
    rst = 1'b0;
    model_seq('{8'h1C});
    drain("t6b");

    // overflow stickiness
    @(negedge clk);
    kbd_overflow = 1'b1;
    @(negedge clk);
    kbd_overflow = 1'b0;
    repeat (3) @(negedge clk);
    check("ovf_sticky", 32'(err_status), 32'b001);
    pulse_clr();
    check("ovf_clr", 32'(err_status), 0);

    // randomized key traffic
    for (int i = 0; i < 300; i++) begin
      c = pick_code();
      case ($urandom_range(0, 6))
        0, 1: send('{c});
        2:    send('{8'hF0, c});
        3:    send('{8'hE0, c});
        4:    send('{8'hE0, 8'hF0, c});
        5:    send('{8'hE1, 8'($urandom), 8'($urandom), 8'($urandom),
                     8'($urandom), 8'($urandom), 8'($urandom),
                     8'($urandom)});
        default: send('{8'hE0, ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59});
      endcase
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      if (fq.size() > 20) drain("rand_mid");
    end
    drain("rand");
    check("rand_err", 32'(err_status), 0);
    check("left_expected", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
